// File: rtl/ext_mem_arbiter.sv
// Purpose: round-robin arbiter giving fetch (m0) and load (m1) one shared external memory read port.
// Latency: grant sampled on edge N, ext_mem_valid after N, requester ready/rdata registered one edge after ext_mem_ready.
// Backpressure: one read outstanding; requesters hold valid/addr until their ready pulse. ARB_TIMEOUT_EN adds a response timeout with err outputs.
module ext_mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ext_mem_valid,
    input  logic              ext_mem_ready,
    output logic [ADDR_W-1:0] ext_mem_addr,
    input  logic [DATA_W-1:0] ext_mem_rdata,
    output logic              grant
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              m0_err,
    output logic              m1_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state_q, state_d;
    logic                ext_valid_d;
    logic [ADDR_W-1:0]   ext_addr_d;
    logic                grant_d;
    logic                win;
    logic                m0_ready_d, m1_ready_d;
    logic [DATA_W-1:0]   m0_rdata_d, m1_rdata_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]          cnt_q, cnt_d;
    logic                m0_err_d, m1_err_d;
`endif

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_d     = state_q;
        ext_valid_d = ext_mem_valid;
        ext_addr_d  = ext_mem_addr;
        grant_d     = grant;
        win         = grant;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata;
        m1_rdata_d  = m1_rdata;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        m0_err_d    = 1'b0;
        m1_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a contest the previous loser wins; otherwise the lone requester.
                    win         = (m0_valid && m1_valid) ? ~grant : m1_valid;
                    grant_d     = win;
                    ext_addr_d  = win ? m1_addr : m0_addr;
                    ext_valid_d = 1'b1;
                    state_d     = REQ;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end
            end
            REQ: begin
                if (ext_mem_ready) begin
                    ext_valid_d = 1'b0;
                    if (grant) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = ext_mem_rdata;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = ext_mem_rdata;
                    end
                    state_d = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    // Memory never answered: complete with all-ones data and flag the error.
                    ext_valid_d = 1'b0;
                    if (grant) begin
                        m1_ready_d = 1'b1;
                        m1_err_d   = 1'b1;
                        m1_rdata_d = '1;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_err_d   = 1'b1;
                        m0_rdata_d = '1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                // One dead cycle lets the served requester drop valid before re-arbitration.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction without a ready pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ext_mem_valid <= 1'b0;
            ext_mem_addr  <= '0;
            grant         <= 1'b1;
            m0_ready      <= 1'b0;
            m1_ready      <= 1'b0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= 8'd0;
            m0_err        <= 1'b0;
            m1_err        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ext_mem_valid <= ext_valid_d;
            ext_mem_addr  <= ext_addr_d;
            grant         <= grant_d;
            m0_ready      <= m0_ready_d;
            m1_ready      <= m1_ready_d;
            m0_rdata      <= m0_rdata_d;
            m1_rdata      <= m1_rdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            m0_err        <= m0_err_d;
            m1_err        <= m1_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Purpose: directed scoreboard bench for ext_mem_arbiter with a behavioural memory responder.
// Latency: memory answers mem_delay+1 negedges after it first sees ext_mem_valid; can be muted.
// Backpressure: requesters hold valid/addr until their ready pulse, then drop or re-request.
module tb_ext_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_ready, m1_ready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ext_mem_valid;
    logic          ext_mem_ready = 1'b0;
    logic [AW-1:0] ext_mem_addr;
    logic [DW-1:0] ext_mem_rdata = '0;
    logic          grant;
`ifdef ARB_TIMEOUT_EN
    logic          m0_err, m1_err;
`endif

    ext_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ext_mem_valid(ext_mem_valid), .ext_mem_ready(ext_mem_ready),
        .ext_mem_addr(ext_mem_addr), .ext_mem_rdata(ext_mem_rdata),
        .grant(grant)
`ifdef ARB_TIMEOUT_EN
        , .m0_err(m0_err), .m1_err(m1_err)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t          q0[$], q1[$];
    logic          gq[$];
    logic [DW-1:0] last0 = '0, last1 = '0;
    int            rem0 = 0, rem1 = 0;
    logic [AW-1:0] nxt0, nxt1;

    logic [DW-1:0] mem [0:255];
    int            mem_delay = 1;
    bit            mem_mute  = 1'b0;
    int            wcnt = 0;
    logic [AW-1:0] last_mem_addr = '0;
    bit            mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: single-cycle ready strobe, data looked up by the address the DUT presents.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            ext_mem_ready = 1'b0;
            wcnt = 0;
        end else if (ext_mem_ready) begin
            ext_mem_ready = 1'b0;
        end else if (ext_mem_valid && !mem_mute) begin
            if (wcnt >= mem_delay) begin
                ext_mem_ready = 1'b1;
                ext_mem_rdata = mem[ext_mem_addr];
                last_mem_addr = ext_mem_addr;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Protocol monitor sampled shortly after each rising edge.
    logic          p_valid = 1'b0, p_r0 = 1'b0, p_r1 = 1'b0;
    logic [AW-1:0] p_addr = '0;
    always @(posedge clk) begin
        #2;
        if (mon_en && rst) begin
            if (ext_mem_ready) check("no_valid_after_ready", ext_mem_valid, 0);
            if (p_valid && ext_mem_valid) check("ext_addr_stable", ext_mem_addr, p_addr);
            if (p_r0) check("m0_ready_one_cycle", m0_ready, 0);
            if (p_r1) check("m1_ready_one_cycle", m1_ready, 0);
        end
        p_valid = ext_mem_valid;
        p_addr  = ext_mem_addr;
        p_r0    = m0_ready;
        p_r1    = m1_ready;
    end

    task automatic issue0(input logic [AW-1:0] a);
        exp_t e;
        e.data = mem[a];
        e.err  = 1'b0;
        q0.push_back(e);
        m0_addr  = a;
        m0_valid = 1'b1;
    endtask

    task automatic issue1(input logic [AW-1:0] a);
        exp_t e;
        e.data = mem[a];
        e.err  = 1'b0;
        q1.push_back(e);
        m1_addr  = a;
        m1_valid = 1'b1;
    endtask

    task automatic handle(input int idx);
        exp_t e;
        logic g;
        if (idx == 0) begin
            if (q0.size() == 0) check("m0_unexpected_ready", m0_ready, 0);
            else begin
                e = q0.pop_front();
                check("m0_rdata", m0_rdata, e.data);
`ifdef ARB_TIMEOUT_EN
                check("m0_err", m0_err, e.err);
`endif
                check("m0_grant", grant, 0);
                check("m1_rdata_hold", m1_rdata, last1);
                last0 = e.data;
            end
            if (rem0 > 0) begin
                rem0--;
                issue0(nxt0);
                nxt0++;
            end else m0_valid = 1'b0;
        end else begin
            if (q1.size() == 0) check("m1_unexpected_ready", m1_ready, 0);
            else begin
                e = q1.pop_front();
                check("m1_rdata", m1_rdata, e.data);
`ifdef ARB_TIMEOUT_EN
                check("m1_err", m1_err, e.err);
`endif
                check("m1_grant", grant, 1);
                check("m0_rdata_hold", m0_rdata, last0);
                last1 = e.data;
            end
            if (rem1 > 0) begin
                rem1--;
                issue1(nxt1);
                nxt1++;
            end else m1_valid = 1'b0;
        end
        if (gq.size() > 0) begin
            g = gq.pop_front();
            check("grant_order", grant, g);
        end
    endtask

    // Waits for n completions at negedges; first = negedge count at the first completion.
    task automatic wait_done(input int n, input int budget, output int first);
        int done = 0;
        int cyc  = 0;
        first = -1;
        while (done < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (m0_ready) begin handle(0); done++; if (first < 0) first = cyc; end
            if (m1_ready) begin handle(1); done++; if (first < 0) first = cyc; end
        end
        check("completions_within_budget", done, n);
    endtask

    initial begin
        int c;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'h2002_0000 ^ ((i ^ 3) * 32'h0001_0101);
        rst = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = '0; m1_addr = '0;

        // Reset state
        #12;
        check("rst_ext_valid", ext_mem_valid, 0);
        check("rst_ext_addr", ext_mem_addr, 0);
        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_grant", grant, 1);
`ifdef ARB_TIMEOUT_EN
        check("rst_m0_err", m0_err, 0);
        check("rst_m1_err", m1_err, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Contest after reset: m0 first, then m1
        gq.push_back(1'b0); gq.push_back(1'b1);
        issue0(8'd1);
        issue1(8'd5);
        wait_done(2, 40, c);
        repeat (2) @(negedge clk);

        // Fairness: both re-request continuously for six transactions
        for (int k = 0; k < 3; k++) begin gq.push_back(1'b0); gq.push_back(1'b1); end
        rem0 = 2; rem1 = 2;
        nxt0 = 8'd11; nxt1 = 8'd21;
        issue0(8'd10);
        issue1(8'd20);
        wait_done(6, 100, c);
        repeat (2) @(negedge clk);

        // Single request with latency check
        issue0(8'd3);
        wait_done(1, 50, c);
        check("single_latency", c, 3);
        check("single_ext_addr", last_mem_addr, 3);
        check("single_rdata_value", m0_rdata, 32'h2002_0000);
        repeat (2) @(negedge clk);

        // Async reset while REQ is pending
        mem_delay = 5;
        issue0(8'd40);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = ext_mem_valid;
        end
        check("req_pending_before_reset", seen, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst_ext_valid", ext_mem_valid, 0);
        check("midrst_m0_ready", m0_ready, 0);
        check("midrst_m1_ready", m1_ready, 0);
        check("midrst_grant", grant, 1);
        check("midrst_m0_rdata", m0_rdata, 0);
        #1 rst = 1'b1;
        last0 = '0; last1 = '0;
        wait_done(1, 60, c);
        mem_delay = 1;
        repeat (2) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Timeout: memory never answers m1
        begin
            exp_t e;
            e.data = '1;
            e.err  = 1'b1;
            q1.push_back(e);
        end
        mem_mute = 1'b1;
        m1_addr  = 8'd7;
        m1_valid = 1'b1;
        wait_done(1, 100, c);
        check("timeout_latency", c, TO + 1);
        mem_mute = 1'b0;
        repeat (2) @(negedge clk);
        issue0(8'd8);
        wait_done(1, 50, c);
        repeat (2) @(negedge clk);
`endif

        check("scoreboard_q0_empty", q0.size(), 0);
        check("scoreboard_q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
